// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// master = core plus memory side (testbench/datapath), slave = mem_access_unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  err;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  rdata, ready, err, busy, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output rdata, ready, err, busy, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V load/store unit: byte/half/word loads with extension, read-modify-write
// sub-word stores, and misaligned/illegal access flagging toward a word memory.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_access_unit_if.slave bus
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  store_q;
  logic [2:0]            f3_q;
  logic [1:0]            lane_q;
  logic [15:0]           wdata_q;
  logic                  err_pend;

  logic [31:0]           rdata_q;
  logic                  ready_q;
  logic                  err_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_re_q;
  logic                  mem_we_q;
  logic [31:0]           mem_wdata_q;

  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           load_val;
  logic [31:0]           merged;

  // Classification of the request currently offered on the bus.
  always_comb begin
    req_illegal    = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                     (bus.funct3 == 3'b111) || (bus.we && bus.funct3[2]);
    req_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    rd_byte = 8'(bus.mem_rdata >> {lane_q, 3'b000});
    rd_half = 16'(bus.mem_rdata >> {lane_q[1], 4'b0000});
    case (f3_q)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'h000000, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'h0000, rd_half};
      default: load_val = bus.mem_rdata;
    endcase
    if (f3_q[0]) begin
      merged = (bus.mem_rdata & ~(32'h0000FFFF << {lane_q[1], 4'b0000})) |
               (32'(wdata_q) << {lane_q[1], 4'b0000});
    end else begin
      merged = (bus.mem_rdata & ~(32'h000000FF << {lane_q, 3'b000})) |
               (32'(wdata_q[7:0]) << {lane_q, 3'b000});
    end
  end

  // Errored requests spend the write slot with the strobe suppressed so that
  // they complete with the same latency as a full-word store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0000;
      err_pend    <= 1'b0;
      rdata_q     <= 32'h0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            store_q    <= bus.we;
            f3_q       <= bus.funct3;
            lane_q     <= bus.addr[1:0];
            wdata_q    <= bus.wdata[15:0];
            mem_addr_q <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
            cnt        <= '0;
            busy_q     <= 1'b1;
            if (req_illegal || req_misaligned) begin
              err_pend <= 1'b1;
              state    <= WR;
            end else if (bus.we && (bus.funct3 == 3'b010)) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.wdata;
              state       <= WR;
            end else begin
              mem_re_q <= 1'b1;
              state    <= RD;
            end
          end
        end
        RD: begin
          if (cnt == CNT_W'(READ_LATENCY)) begin
            mem_re_q <= 1'b0;
            if (store_q) begin
              mem_wdata_q <= merged;
              mem_we_q    <= 1'b1;
              state       <= WR;
            end else begin
              rdata_q <= load_val;
              ready_q <= 1'b1;
              state   <= DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          mem_we_q <= 1'b0;
          ready_q  <= 1'b1;
          if (err_pend) begin
            err_q    <= 1'b1;
            rdata_q  <= 32'h0;
            err_pend <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) driven with the
// same requests, each backed by its own word memory, checked against a reference model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  logic load_mem;

  mem_access_unit_if #(.ADDR_WIDTH(32)) if1 ();
  mem_access_unit_if #(.ADDR_WIDTH(32)) if3 ();

  mem_access_unit #(.ADDR_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );
  mem_access_unit #(.ADDR_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe3 [2];
  logic [31:0] ref_mem [256];

  // Word memories; unread cycles return a marker so early sampling is visible.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= ref_mem[i];
        mem3[i] <= ref_mem[i];
      end
    end else begin
      if (if1.mem_we) mem1[if1.mem_addr[9:2]] <= if1.mem_wdata;
      if (if3.mem_we) mem3[if3.mem_addr[9:2]] <= if3.mem_wdata;
    end
    if1.mem_rdata <= if1.mem_re ? mem1[if1.mem_addr[9:2]] : 32'h0BAD0BAD;
    pipe3[0]      <= if3.mem_re ? mem3[if3.mem_addr[9:2]] : 32'h0BAD0BAD;
    pipe3[1]      <= pipe3[0];
    if3.mem_rdata <= pipe3[1];
  end

  logic [1:0]  d_ready, d_err, d_busy, d_re, d_we;
  logic [31:0] d_rdata [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_maddr [2];

  always_comb begin
    d_ready    = {if3.ready, if1.ready};
    d_err      = {if3.err, if1.err};
    d_busy     = {if3.busy, if1.busy};
    d_re       = {if3.mem_re, if1.mem_re};
    d_we       = {if3.mem_we, if1.mem_we};
    d_rdata[0] = if1.rdata;     d_rdata[1] = if3.rdata;
    d_wdata[0] = if1.mem_wdata; d_wdata[1] = if3.mem_wdata;
    d_maddr[0] = if1.mem_addr;  d_maddr[1] = if3.mem_addr;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model expectations and last observed transaction.
  logic [31:0] last_rdata;
  logic        e_err;
  logic [31:0] e_rdata, e_wword, e_waddr;
  int          e_wcnt;
  int          e_lat [2];
  int          e_recnt [2];

  int          o_lat [2];
  int          o_rcnt [2];
  int          o_wcnt [2];
  int          o_recnt [2];
  logic        o_err [2];
  logic [31:0] o_rdata [2];
  logic [31:0] o_wword [2];
  logic [31:0] o_waddr [2];

  task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if1.req = r; if1.we = w; if1.funct3 = f3; if1.addr = a; if1.wdata = wd;
    if3.req = r; if3.we = w; if3.funct3 = f3; if3.addr = a; if3.wdata = wd;
  endtask

  // Architectural outcome of one access, straight from the ISA rules.
  task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    logic        ill, mis;
    logic [31:0] word, v, nw;
    int unsigned sh;
    int          lat_l [2];
    lat_l[0] = 1; lat_l[1] = 3;
    ill  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (w && (f3 == 4 || f3 == 5));
    mis  = ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 2'b00);
    word = ref_mem[a[9:2]];
    e_waddr = {a[31:2], 2'b00};
    e_wcnt  = 0;
    e_wword = 32'h0;
    for (int d = 0; d < 2; d++) e_recnt[d] = 0;
    if (ill || mis) begin
      e_err = 1'b1; e_rdata = 32'h0; last_rdata = 32'h0;
      for (int d = 0; d < 2; d++) e_lat[d] = 1;
    end else if (w) begin
      e_err = 1'b0; e_rdata = last_rdata; e_wcnt = 1;
      if (f3 == 2) begin
        nw = wd;
        for (int d = 0; d < 2; d++) e_lat[d] = 1;
      end else begin
        if (f3 == 0) begin
          sh = 8 * a[1:0];
          nw = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        end else begin
          sh = 16 * a[1];
          nw = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
        end
        for (int d = 0; d < 2; d++) begin
          e_lat[d] = lat_l[d] + 2; e_recnt[d] = lat_l[d] + 1;
        end
      end
      e_wword = nw;
      ref_mem[a[9:2]] = nw;
    end else begin
      e_err = 1'b0;
      if (f3 == 0 || f3 == 4) begin
        v = (word >> (8 * a[1:0])) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (f3 == 1 || f3 == 5) begin
        v = (word >> (16 * a[1])) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
      end else begin
        v = word;
      end
      e_rdata = v; last_rdata = v;
      for (int d = 0; d < 2; d++) begin
        e_lat[d] = lat_l[d] + 1; e_recnt[d] = lat_l[d] + 1;
      end
    end
  endtask

  // Issue one request (from #1 after an edge, both units idle) and record what happens.
  task automatic run_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    model(w, f3, a, wd);
    drive(1'b1, w, f3, a, wd);
    @(posedge clk); #1;
    drive(1'b0, $urandom_range(0, 1), 3'($urandom), $urandom, $urandom);
    for (int d = 0; d < 2; d++) begin
      o_lat[d] = -1; o_rcnt[d] = 0; o_wcnt[d] = 0; o_recnt[d] = 0;
      o_err[d] = 1'bx; o_rdata[d] = 32'hx; o_wword[d] = 32'hx; o_waddr[d] = 32'hx;
    end
    for (int k = 0; k < 40; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (d_ready[d]) begin
          if (o_lat[d] < 0) begin
            o_lat[d] = k; o_rdata[d] = d_rdata[d]; o_err[d] = d_err[d];
          end
          o_rcnt[d]++;
        end
        if (d_we[d]) begin
          o_wcnt[d]++; o_wword[d] = d_wdata[d]; o_waddr[d] = d_maddr[d];
        end
        if (d_re[d]) o_recnt[d]++;
      end
      if (o_lat[0] >= 0 && o_lat[1] >= 0 && d_ready == 2'b00) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (d_rdata[d] !== 32'h0 || d_wdata[d] !== 32'h0 || d_maddr[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: got rdata=%h mem_wdata=%h mem_addr=%h, expected 0",
                 d, d_rdata[d], d_wdata[d], d_maddr[d]);
      end
      n_tests++;
      if ({d_ready[d], d_err[d], d_busy[d], d_re[d], d_we[d]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: got ready/err/busy/re/we=%b, expected 00000", d,
                 {d_ready[d], d_err[d], d_busy[d], d_re[d], d_we[d]});
      end
    end
  endtask

  task automatic test_load_word;
    int exp_lat [2];
    exp_lat[0] = 2; exp_lat[1] = 4;
    run_op(1'b0, 3'b010, 32'h40, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rdata[d] !== 32'h8765F0A1 || o_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL lw dut%0d: got rdata=%h err=%b, expected 8765f0a1 err=0", d, o_rdata[d], o_err[d]);
      end
      n_tests++;
      if (o_lat[d] != exp_lat[d] || o_wcnt[d] != 0 || o_rcnt[d] != 1) begin
        n_fail++;
        $display("FAIL lw_timing dut%0d: got lat=%0d we_cycles=%0d ready_cycles=%0d, expected %0d 0 1",
                 d, o_lat[d], o_wcnt[d], o_rcnt[d], exp_lat[d]);
      end
    end
  endtask

  task automatic test_load_lanes;
    logic [2:0]  f3s  [5];
    logic [31:0] adrs [5];
    logic [31:0] exps [5];
    f3s[0] = 3'b000; adrs[0] = 32'h41; exps[0] = 32'hFFFFFFF0;
    f3s[1] = 3'b100; adrs[1] = 32'h41; exps[1] = 32'h000000F0;
    f3s[2] = 3'b001; adrs[2] = 32'h42; exps[2] = 32'hFFFF8765;
    f3s[3] = 3'b101; adrs[3] = 32'h42; exps[3] = 32'h00008765;
    f3s[4] = 3'b000; adrs[4] = 32'h40; exps[4] = 32'hFFFFFFA1;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, f3s[i], adrs[i], 32'h0);
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (o_rdata[d] !== exps[i] || o_err[d] !== 1'b0 || o_lat[d] != e_lat[d]) begin
          n_fail++;
          $display("FAIL load_lane%0d dut%0d: got rdata=%h err=%b lat=%0d, expected %h 0 %0d",
                   i, d, o_rdata[d], o_err[d], o_lat[d], exps[i], e_lat[d]);
        end
      end
    end
  endtask

  task automatic test_errors;
    logic        ws   [3];
    logic [2:0]  f3s  [3];
    logic [31:0] adrs [3];
    ws[0] = 1'b1; f3s[0] = 3'b001; adrs[0] = 32'h41;
    ws[1] = 1'b0; f3s[1] = 3'b011; adrs[1] = 32'h40;
    ws[2] = 1'b1; f3s[2] = 3'b100; adrs[2] = 32'h40;
    for (int i = 0; i < 3; i++) begin
      run_op(ws[i], f3s[i], adrs[i], 32'hFFFF_BEEF);
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (o_err[d] !== 1'b1 || o_rdata[d] !== 32'h0 || o_lat[d] != 1) begin
          n_fail++;
          $display("FAIL error%0d dut%0d: got err=%b rdata=%h lat=%0d, expected 1 0 1",
                   i, d, o_err[d], o_rdata[d], o_lat[d]);
        end
        n_tests++;
        if (o_wcnt[d] != 0 || o_recnt[d] != 0) begin
          n_fail++;
          $display("FAIL error%0d_strobes dut%0d: got re_cycles=%0d we_cycles=%0d, expected 0 0",
                   i, d, o_recnt[d], o_wcnt[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op;
    drive(1'b1, 1'b1, 3'b001, 32'h42, 32'h0000BEEF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    n_tests++;
    if (d_busy !== 2'b11 || d_re !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: got busy=%b re=%b, expected 11 11", d_busy, d_re);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (d_busy !== 2'b00 || d_we !== 2'b00 || d_re !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_async: got busy=%b we=%b re=%b, expected 00 00 00", d_busy, d_we, d_re);
    end
    @(posedge clk); #1;
    n_tests++;
    if (d_we !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_we: got we=%b, expected 00", d_we);
    end
    reset = 1'b1;
    last_rdata = 32'h0;
    @(posedge clk); #1;
    run_op(1'b0, 3'b010, 32'h40, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rdata[d] !== 32'h8765F0A1 || o_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_lw dut%0d: got rdata=%h err=%b, expected 8765f0a1 0", d, o_rdata[d], o_err[d]);
      end
    end
  endtask

  task automatic test_sub_store;
    int exp_lat [2];
    int exp_re [2];
    exp_lat[0] = 3; exp_lat[1] = 5;
    exp_re[0]  = 2; exp_re[1]  = 4;
    run_op(1'b1, 3'b000, 32'h43, 32'h123456CC);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_wcnt[d] != 1 || o_wword[d] !== 32'hCC65F0A1 || o_waddr[d] !== 32'h40) begin
        n_fail++;
        $display("FAIL sb_write dut%0d: got we_cycles=%0d data=%h addr=%h, expected 1 cc65f0a1 40",
                 d, o_wcnt[d], o_wword[d], o_waddr[d]);
      end
      n_tests++;
      if (o_recnt[d] != exp_re[d] || o_lat[d] != exp_lat[d] || o_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_timing dut%0d: got re_cycles=%0d lat=%0d err=%b, expected %0d %0d 0",
                 d, o_recnt[d], o_lat[d], o_err[d], exp_re[d], exp_lat[d]);
      end
    end
    run_op(1'b0, 3'b010, 32'h40, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rdata[d] !== 32'hCC65F0A1) begin
        n_fail++;
        $display("FAIL sb_readback dut%0d: got %h, expected cc65f0a1", d, o_rdata[d]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_ready [6];
    logic [1:0] exp_busy  [6];
    logic [1:0] exp_we    [6];
    int         exp_lat [2];
    exp_lat[0] = 2; exp_lat[1] = 4;
    exp_ready = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};
    exp_busy  = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00};
    exp_we    = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00};
    drive(1'b1, 1'b1, 3'b010, 32'h44, 32'hDEADBEEF);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 3) drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      n_tests++;
      if (d_ready !== exp_ready[k] || d_busy !== exp_busy[k] || d_we !== exp_we[k]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got ready=%b busy=%b we=%b, expected %b %b %b",
                 k, d_ready, d_busy, d_we, exp_ready[k], exp_busy[k], exp_we[k]);
      end
    end
    ref_mem[32'h44 >> 2] = 32'hDEADBEEF;
    run_op(1'b0, 3'b010, 32'h44, 32'h0);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (o_rdata[d] !== 32'hDEADBEEF || o_lat[d] != exp_lat[d]) begin
        n_fail++;
        $display("FAIL b2b_lw dut%0d: got rdata=%h lat=%0d, expected deadbeef %0d",
                 d, o_rdata[d], o_lat[d], exp_lat[d]);
      end
    end
  endtask

  task automatic test_random;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h40 + 32'($urandom_range(0, 63));
      run_op(w, f3, a, $urandom);
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (o_err[d] !== e_err || o_rdata[d] !== e_rdata || o_lat[d] != e_lat[d] || o_rcnt[d] != 1) begin
          n_fail++;
          $display("FAIL rand%0d dut%0d (we=%b f3=%0d a=%h): got err=%b rdata=%h lat=%0d ready_cycles=%0d, expected %b %h %0d 1",
                   i, d, w, f3, a, o_err[d], o_rdata[d], o_lat[d], o_rcnt[d], e_err, e_rdata, e_lat[d]);
        end
        n_tests++;
        if (o_wcnt[d] != e_wcnt || o_recnt[d] != e_recnt[d] ||
            (e_wcnt == 1 && (o_wword[d] !== e_wword || o_waddr[d] !== e_waddr))) begin
          n_fail++;
          $display("FAIL rand%0d_mem dut%0d: got we_cycles=%0d re_cycles=%0d wdata=%h addr=%h, expected %0d %0d %h %h",
                   i, d, o_wcnt[d], o_recnt[d], o_wword[d], o_waddr[d], e_wcnt, e_recnt[d], e_wword, e_waddr);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    load_mem = 1'b1;
    last_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[32'h40 >> 2] = 32'h8765F0A1;
    repeat (2) @(posedge clk);
    #1;
    load_mem = 1'b0;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    test_load_word();
    test_load_lanes();
    test_errors();
    test_reset_mid_op();
    test_sub_store();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
